xup_debounce_vector: RTL and testbench



---
 rtl/xup_debounce_vector.sv | 55 +++++
 tb/tb_xup_debounce_vector.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/xup_debounce_vector.sv
// xup_debounce_vector: per-bit two-flop synchroniser and counter debouncer for raw board inputs.
// Define XUP_DEBOUNCE_EDGE_EN to build registered rise/fall strobes; otherwise they are tied to 0.
module xup_debounce_vector #(
    parameter int SIZE          = 2,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_WIDTH     = 20
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] y,
    output logic [SIZE-1:0] rise,
    output logic [SIZE-1:0] fall
);
    localparam logic [CNT_WIDTH-1:0] TERM = CNT_WIDTH'(STABLE_CYCLES - 1);
    logic [SIZE-1:0]                s1_q, s2_q, y_q, y_d;
    logic [SIZE-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
    for (genvar g = 0; g < SIZE; g++) begin : g_bit
        logic diff, done;
        assign diff     = s2_q[g] ^ y_q[g];
        assign done     = diff && cnt_q[g] == TERM;
        assign y_d[g]   = done ? s2_q[g] : y_q[g];
        // any return of s2 to y, or an accepted toggle, restarts qualification from zero
        assign cnt_d[g] = (diff && !done) ? cnt_q[g] + 1'b1 : '0;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            s1_q  <= '0;
            s2_q  <= '0;
            y_q   <= '0;
            cnt_q <= '0;
        end else begin
            s1_q  <= d;
            s2_q  <= s1_q;
            y_q   <= y_d;
            cnt_q <= cnt_d;
        end
    assign y = y_q;
`ifdef XUP_DEBOUNCE_EDGE_EN
    logic [SIZE-1:0] rise_q, fall_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= y_d & ~y_q;
            fall_q <= ~y_d & y_q;
        end
    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = '0;
    assign fall = '0;
`endif
endmodule

// File: tb/tb_xup_debounce_vector.sv
// tb_xup_debounce_vector: table vectors, directed corner sequences and randomized stimulus
// checked against a sliding-window reference model of the debouncer.
module tb_xup_debounce_vector;
    localparam int S = 4;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] d = 2'b11;
    logic [1:0] y, rise, fall;
    int         checks = 0;
    int         errors = 0;
    logic [1:0] hist[$];
    logic [1:0] my = 2'b00, mr = 2'b00, mf = 2'b00;
    typedef struct {
        logic [1:0] d;
        logic [1:0] y;
        logic [1:0] r;
        logic [1:0] f;
    } vec_t;
    vec_t tbl[8];

    always #5 clk = ~clk;

    xup_debounce_vector #(.SIZE(2), .STABLE_CYCLES(S), .CNT_WIDTH(3)) dut (
        .clk(clk), .reset_n(reset_n), .d(d), .y(y), .rise(rise), .fall(fall)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [1:0] edge_mask(logic [1:0] v);
`ifdef XUP_DEBOUNCE_EDGE_EN
        return v;
`else
        return 2'b00 & v;
`endif
    endfunction

    task automatic check(string name, logic [1:0] act, logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // history holds the d value seen at each edge; s2 before edge n is d from edge n-2
    task automatic model_reset();
        hist.delete();
        repeat (S + 2) hist.push_back(2'b00);
        my = 2'b00;
        mr = 2'b00;
        mf = 2'b00;
    endtask

    task automatic model_edge();
        logic [1:0] old;
        bit         all;
        old = my;
        hist.push_back(d);
        if (hist.size() > S + 2) void'(hist.pop_front());
        for (int b = 0; b < 2; b++) begin
            all = 1'b1;
            for (int j = 0; j < S; j++)
                if (hist[hist.size() - 3 - j][b] == old[b]) all = 1'b0;
            if (all) my[b] = ~old[b];
        end
        mr = edge_mask(my & ~old);
        mf = edge_mask(~my & old);
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".y"}, y, my);
        check({tag, ".rise"}, rise, mr);
        check({tag, ".fall"}, fall, mf);
    endtask

    task automatic async_pulse(string tag);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check({tag, ".y"}, y, 2'b00);
        check({tag, ".rise"}, rise, 2'b00);
        check({tag, ".fall"}, fall, 2'b00);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++) begin
            tbl[i].d = 2'b01;
            tbl[i].y = (i >= 5) ? 2'b01 : 2'b00;
            tbl[i].r = (i == 5) ? 2'b01 : 2'b00;
            tbl[i].f = 2'b00;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst.y", y, 2'b00);
        check("rst.rise", rise, 2'b00);
        check("rst.fall", fall, 2'b00);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = tbl[i].d;
            @(posedge clk);
            model_edge();
            #1;
            check("tbl.y", y, tbl[i].y);
            check("tbl.rise", rise, edge_mask(tbl[i].r));
            check("tbl.fall", fall, edge_mask(tbl[i].f));
            check("tbl.model", y, my);
        end
        d = 2'b11;
        repeat (3) tick("glitch");
        d = 2'b01;
        repeat (8) tick("glitch_rec");
        check("glitch.y", y, 2'b01);
        d = 2'b11;
        repeat (8) tick("settle11");
        check("settle11.y", y, 2'b11);
        d = 2'b10;
        for (int i = 1; i <= 8; i++) begin
            tick("fall");
            if (i == 5) check("fall.y_before", y, 2'b11);
            if (i == 6) begin
                check("fall.y_edge", y, 2'b10);
                check("fall.strobe", fall, edge_mask(2'b01));
            end
            if (i == 7) check("fall.strobe_end", fall, 2'b00);
        end
        d = 2'b00;
        repeat (8) tick("settle00");
        d = 2'b01;
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) d = 2'b11;
            tick("indep");
            if (i == 5) check("indep.y5", y, 2'b00);
            if (i == 6) begin
                check("indep.y6", y, 2'b01);
                check("indep.rise6", rise, edge_mask(2'b01));
            end
            if (i == 7) check("indep.rise7", rise, 2'b00);
            if (i == 8) begin
                check("indep.y8", y, 2'b11);
                check("indep.rise8", rise, edge_mask(2'b10));
            end
        end
        d = 2'b10;
        repeat (8) tick("settle10");
        check("settle10.y", y, 2'b10);
        d = 2'b11;
        repeat (4) tick("midcount");
        async_pulse("midrst");
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick("requal");
            if (n == 0 && y == 2'b11) n = i;
        end
        check_int("requal.edges", n, 6);
        for (int t = 0; t < 400; t++) begin
            for (int b = 0; b < 2; b++)
                if ($urandom_range(4) == 0) d[b] = ~d[b];
            tick("rand");
            if ($urandom_range(60) == 0) async_pulse("rand_rst");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
